// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, NOP encoding and fetch fault causes
package cpu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        FETCH_FAULT_NONE       = 2'd0,
        FETCH_FAULT_MISALIGNED = 2'd1,
        FETCH_FAULT_RANGE      = 2'd2
    } fetch_fault_e;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - combinational next-PC, output-slot and fault decision
import cpu_pkg::*;

module fetch_next_pc #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic [63:0] pc,
    input  logic        fault,
    input  logic [1:0]  fault_cause,
    input  logic        halt,
    input  logic        out_valid,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] pc_next,
    output logic        out_valid_next,
    output logic        capture,
    output logic        fault_next,
    output logic [1:0]  fault_cause_next
);

    logic slot_free;
    logic in_range;

    assign slot_free = !out_valid || out_ready;
    assign in_range  = (pc >> ADDR_WIDTH) == '0;

    always_comb begin
        pc_next          = pc;
        out_valid_next   = out_valid;
        capture          = 1'b0;
        fault_next       = fault;
        fault_cause_next = fault_cause;

        // Once faulted, redirects are ignored; the buffered word may only drain.
        if (redirect_valid && !fault) begin
            out_valid_next = 1'b0;
            if (!is_word_aligned(redirect_pc)) begin
                fault_next       = 1'b1;
                fault_cause_next = FETCH_FAULT_MISALIGNED;
            end else begin
                pc_next = redirect_pc;
            end
        end else if (fault) begin
            if (out_valid && out_ready) begin
                out_valid_next = 1'b0;
            end
        end else if (slot_free && !halt && !in_range) begin
            fault_next       = 1'b1;
            fault_cause_next = FETCH_FAULT_RANGE;
            out_valid_next   = 1'b0;
        end else if (slot_free && !halt) begin
            capture        = 1'b1;
            out_valid_next = 1'b1;
            pc_next        = pc + 64'd4;
        end else if (out_valid && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, output register and fault state
import cpu_pkg::*;

module fetch_unit #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_instr,
    input  logic                  redirect_valid,
    input  logic [63:0]           redirect_pc,
    input  logic                  halt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [63:0]           out_pc,
    output logic                  fault,
    output logic [1:0]            fault_cause
);

    logic [63:0] pc;
    logic [63:0] pc_next;
    logic        out_valid_next;
    logic        capture;
    logic        fault_next;
    logic [1:0]  fault_cause_next;

    assign imem_addr = pc[ADDR_WIDTH-1:0];

    fetch_next_pc #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_next_pc (
        .pc               (pc),
        .fault            (fault),
        .fault_cause      (fault_cause),
        .halt             (halt),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .pc_next          (pc_next),
        .out_valid_next   (out_valid_next),
        .capture          (capture),
        .fault_next       (fault_next),
        .fault_cause_next (fault_cause_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= NOP_INSTR;
            out_pc      <= '0;
            fault       <= 1'b0;
            fault_cause <= FETCH_FAULT_NONE;
        end else begin
            pc          <= pc_next;
            out_valid   <= out_valid_next;
            fault       <= fault_next;
            fault_cause <= fault_cause_next;
            // out_instr/out_pc only move on capture, so they stay stable under stall.
            if (capture) begin
                out_instr <= imem_instr;
                out_pc    <= pc;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of instr_mem. It owns the 64-bit program counter and drives the byte address into instr_mem. It captures the returned 32-bit word into a one-entry output register and hands it to decode over a valid/ready handshake. It also handles control-flow redirects, halt, and misaligned or out-of-range fetch faults.

Parameters:
ADDR_WIDTH, 12, byte-address width of instr_mem; legal PCs are 0 .. 2^ADDR_WIDTH-4.
RESET_PC, 64'h0, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
imem_addr  out  ADDR_WIDTH  byte address to instr_mem; equals pc[ADDR_WIDTH-1:0], combinational.
imem_instr  in  32  word returned by instr_mem, combinational, same cycle.
redirect_valid  in  1  branch/jump taken; load redirect_pc.
redirect_pc  in  64  target byte address.
halt  in  1  suppress new fetches while high.
out_valid  out  1  out_instr/out_pc hold a fetched instruction.
out_ready  in  1  decode accepts the instruction this cycle.
out_instr  out  32  fetched instruction.
out_pc  out  64  PC of out_instr.
fault  out  1  sticky fetch fault; fetch stops.
fault_cause  out  2  0 = none, 1 = misaligned target, 2 = PC out of range.

Behaviour:
Reset values:
- pc = RESET_PC, out_valid = 0, out_instr = 32'h00000013 (NOP), out_pc = 0, fault = 0, fault_cause = 0.
- Reset asserted mid-operation discards any buffered instruction immediately.

Definitions:
- slot_free = !out_valid | out_ready.
- in_range = (pc >> ADDR_WIDTH) == 0.
- can_fetch = !fault & !halt & slot_free & in_range & !redirect_valid.

Priority per cycle (highest first):
1. redirect_valid:
   - out_valid <= 0 (flush).
   - If redirect_pc[1:0] != 0: fault <= 1, fault_cause <= 1, pc unchanged.
   - Otherwise pc <= redirect_pc.
   - An instruction with out_valid & out_ready in the same cycle is considered consumed; no duplicate is produced.
2. fault set: no fetch. out_valid may still drain through a handshake.
3. !fault & slot_free & !halt & !in_range: fault <= 1, fault_cause <= 2, out_valid <= 0 once drained.
4. can_fetch: out_instr <= imem_instr, out_pc <= pc, out_valid <= 1, pc <= pc + 4 (mod 2^64).
5. Otherwise, out_valid & out_ready (halt or fault draining): out_valid <= 0, pc holds.
6. Stall (out_valid & !out_ready, no redirect): all outputs and pc hold stable.

Other rules:
- Latency: instruction at pc appears on out_* one cycle after imem_addr = pc. Sustained throughput is 1 instruction/cycle while out_ready = 1.
- Fault is sticky until rst. While fault = 1, redirect is ignored.
- out_instr and out_pc must not change while out_valid & !out_ready.
- halt deasserting resumes fetch at the held pc, with no skipped or duplicated PC.

Decomposition:
- Shared package cpu_pkg:
  - XLEN = 64, ILEN = 32.
  - NOP_INSTR = 32'h00000013.
  - Fault-cause constants FETCH_FAULT_NONE / MISALIGNED / RANGE.
- One natural sub-module: fetch_next_pc, a combinational next-PC and fault-decision select (priority list above).
- The fetch_unit top holds only the registers.
- instr_mem is instantiated by the core top, not inside fetch_unit.

Test Plan:
1. Sequential fetch: instr_mem preloaded 0x00000013, 0x00100093, 0x00200113, 0x00308193; out_ready = 1 after reset -> four consecutive accepts with (out_pc, out_instr) = (0x0, 0x00000013), (0x4, 0x00100093), (0x8, 0x00200113), (0xC, 0x00308193).
2. Backpressure: out_ready = 0 for 3 cycles while holding pc 0x4 -> out_pc/out_instr stay 0x4/0x00100093 and imem_addr stays 0x008. Release -> next accept is pc 0x8, with none skipped or duplicated.
3. Redirect: redirect_valid with redirect_pc = 0x0 while out_pc = 0x8 and out_ready = 0 -> next cycle out_valid = 0; following cycle out_pc = 0x0, out_instr = 0x00000013.
4. Misaligned redirect: redirect_pc = 0x6 -> fault = 1, fault_cause = 1, out_valid = 0, and no further fetches despite out_ready = 1.
5. Range fault: redirect_pc = 0xFFC with ADDR_WIDTH = 12 -> fetch at 0xFFC succeeds, then pc = 0x1000 -> fault = 1, fault_cause = 2.
6. Halt and async reset: halt = 1 at pc 0x8 -> out_valid drains to 0 and pc holds 0x8; halt = 0 -> out_pc = 0x8 next. Pulse rst between clock edges -> out_valid = 0 and pc = RESET_PC immediately.
